// File: rtl/framebuffer_writer_if.sv
// Line-capture stream in and BRAM write port out of framebuffer_writer.
// The capture side holds master and the writer holds slave.
interface framebuffer_writer_if #(
  parameter int PIXEL_WIDTH = 12,
  parameter int ADDR_WIDTH  = 17
);
  logic                   axiiv;
  logic [PIXEL_WIDTH-1:0] axiid;
  logic [7:0]             line_y;
  logic                   frame_swap;
  logic                   axiov;
  logic [ADDR_WIDTH-1:0]  bram_addr;
  logic [PIXEL_WIDTH-1:0] bram_data_in;

  modport master (
    output axiiv, axiid, line_y, frame_swap,
    input  axiov, bram_addr, bram_data_in
  );

  modport slave (
    input  axiiv, axiid, line_y, frame_swap,
    output axiov, bram_addr, bram_data_in
  );
endinterface

// File: rtl/framebuffer_writer.sv
// Writes one captured pixel line per valid run into a BRAM frame store, with
// ping-pong buffering, horizontal clipping, line rejection and sticky error flags.
module framebuffer_writer #(
  parameter int FRAME_WIDTH  = 256,
  parameter int FRAME_HEIGHT = 256,
  parameter int PIXEL_WIDTH  = 12,
  parameter int NUM_BUFFERS  = 2,
  parameter int ADDR_WIDTH   = 17
) (
  input  logic                 clk,
  input  logic                 rst,
  framebuffer_writer_if.slave  bus,
  output logic                 display_buf,
  output logic [7:0]           lines_written,
  output logic                 err_clip,
  output logic                 err_line
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WRITE = 2'd1;
  localparam logic [1:0] DROP  = 2'd2;

  localparam int XW = $clog2(FRAME_WIDTH + 1);
  localparam logic [ADDR_WIDTH-1:0] BUF_SIZE = ADDR_WIDTH'(FRAME_WIDTH * FRAME_HEIGHT);
  localparam logic [ADDR_WIDTH-1:0] FW_A     = ADDR_WIDTH'(FRAME_WIDTH);

  logic [1:0]            state;
  logic [XW-1:0]         x;
  logic [7:0]            y;
  logic                  wbuf;
  logic                  swap_pending;
  logic                  drop_counts;

  logic                  idle_swap;
  logic                  wbuf_eff;
  logic [7:0]            y_sel;
  logic [XW-1:0]         x_sel;
  logic [ADDR_WIDTH-1:0] addr_next;
  logic                  line_ok;
  logic                  x_in_range;
  logic [7:0]            lw_inc;

  // A swap taking effect in IDLE also redirects a line starting that same cycle.
  always_comb begin
    idle_swap  = (state == IDLE) && (bus.frame_swap || swap_pending);
    wbuf_eff   = ((NUM_BUFFERS > 1) && idle_swap) ? ~wbuf : wbuf;
    y_sel      = (state == IDLE) ? bus.line_y : y;
    x_sel      = (state == IDLE) ? '0 : x;
    addr_next  = (wbuf_eff ? BUF_SIZE : '0)
               + ADDR_WIDTH'(y_sel) * FW_A
               + ADDR_WIDTH'(x_sel);
    line_ok    = 32'(bus.line_y) < FRAME_HEIGHT;
    x_in_range = 32'(x) < FRAME_WIDTH;
    lw_inc     = (lines_written == 8'hFF) ? 8'hFF : lines_written + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      x                <= '0;
      y                <= '0;
      wbuf             <= (NUM_BUFFERS > 1);
      swap_pending     <= 1'b0;
      drop_counts      <= 1'b0;
      display_buf      <= 1'b0;
      lines_written    <= '0;
      err_clip         <= 1'b0;
      err_line         <= 1'b0;
      bus.axiov        <= 1'b0;
      bus.bram_addr    <= '0;
      bus.bram_data_in <= '0;
    end else begin
      bus.axiov <= 1'b0;
      case (state)
        IDLE: begin
          if (idle_swap) begin
            swap_pending  <= 1'b0;
            lines_written <= '0;
            if (NUM_BUFFERS > 1) begin
              display_buf <= wbuf;
              wbuf        <= ~wbuf;
            end
          end
          if (bus.axiiv) begin
            if (line_ok) begin
              y                <= bus.line_y;
              x                <= XW'(1);
              bus.axiov        <= 1'b1;
              bus.bram_addr    <= addr_next;
              bus.bram_data_in <= bus.axiid;
              state            <= WRITE;
            end else begin
              err_line    <= 1'b1;
              drop_counts <= 1'b0;
              state       <= DROP;
            end
          end
        end
        WRITE: begin
          if (bus.frame_swap) swap_pending <= 1'b1;
          if (bus.axiiv) begin
            if (x_in_range) begin
              x                <= x + XW'(1);
              bus.axiov        <= 1'b1;
              bus.bram_addr    <= addr_next;
              bus.bram_data_in <= bus.axiid;
            end else begin
              err_clip    <= 1'b1;
              drop_counts <= 1'b1;
              state       <= DROP;
            end
          end else begin
            lines_written <= lw_inc;
            state         <= IDLE;
          end
        end
        DROP: begin
          if (bus.frame_swap) swap_pending <= 1'b1;
          if (!bus.axiiv) begin
            // Clipped lines still count as written; rejected lines do not.
            if (drop_counts) lines_written <= lw_inc;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_framebuffer_writer.sv
// Self-checking bench for framebuffer_writer: reset checks, a table of line
// transactions, hand-written corner sequences and a randomized model-checked run.
module tb_framebuffer_writer;

  localparam int FW = 256;
  localparam int FH = 256;
  localparam int PW = 12;
  localparam int AW = 17;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          v;
  logic [PW-1:0] d;
  logic [7:0]    ly;
  logic          sw;

  framebuffer_writer_if #(.PIXEL_WIDTH(PW), .ADDR_WIDTH(AW)) fb ();
  framebuffer_writer_if #(.PIXEL_WIDTH(PW), .ADDR_WIDTH(AW)) fbs ();

  assign fb.axiiv       = v;
  assign fb.axiid       = d;
  assign fb.line_y      = ly;
  assign fb.frame_swap  = sw;
  assign fbs.axiiv      = v;
  assign fbs.axiid      = d;
  assign fbs.line_y     = ly;
  assign fbs.frame_swap = sw;

  logic       display_buf, err_clip, err_line;
  logic [7:0] lines_written;
  logic       s_display_buf, s_err_clip, s_err_line;
  logic [7:0] s_lines_written;

  framebuffer_writer #(
    .FRAME_WIDTH(FW), .FRAME_HEIGHT(FH), .PIXEL_WIDTH(PW), .NUM_BUFFERS(2), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .rst(rst), .bus(fb.slave),
    .display_buf(display_buf), .lines_written(lines_written),
    .err_clip(err_clip), .err_line(err_line)
  );

  // Shorter frame so that 8-bit line indices can fall out of range.
  framebuffer_writer #(
    .FRAME_WIDTH(FW), .FRAME_HEIGHT(200), .PIXEL_WIDTH(PW), .NUM_BUFFERS(2), .ADDR_WIDTH(AW)
  ) dut_short (
    .clk(clk), .rst(rst), .bus(fbs.slave),
    .display_buf(s_display_buf), .lines_written(s_lines_written),
    .err_clip(s_err_clip), .err_line(s_err_line)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state, expressed per line run rather than per FSM state.
  int m_wbuf, m_in_run, m_len, m_y, m_ok, m_pend;
  int e_v, e_addr, e_data, e_lw, e_disp, e_clip, e_errl;

  int nwr, nswr, first_addr, last_addr;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic model_cycle(input logic iv, input logic [PW-1:0] id, input logic [7:0] iy,
                             input logic isw, input logic irst);
    e_v = 0;
    if (irst) begin
      m_wbuf = 1; m_in_run = 0; m_pend = 0; m_len = 0; m_y = 0; m_ok = 0;
      e_addr = 0; e_data = 0; e_lw = 0; e_disp = 0; e_clip = 0; e_errl = 0;
      return;
    end
    if (m_in_run == 0) begin
      if (isw || m_pend != 0) begin
        e_disp = m_wbuf;
        m_wbuf = 1 - m_wbuf;
        e_lw   = 0;
        m_pend = 0;
      end
      if (iv) begin
        m_in_run = 1;
        m_len    = 0;
        m_y      = int'(iy);
        m_ok     = (int'(iy) < FH) ? 1 : 0;
        if (m_ok == 0) e_errl = 1;
      end
    end else begin
      if (isw) m_pend = 1;
      if (!iv) begin
        m_in_run = 0;
        if (m_ok != 0 && e_lw < 255) e_lw++;
      end
    end
    if (iv && m_in_run != 0 && m_ok != 0) begin
      if (m_len < FW) begin
        e_v    = 1;
        e_addr = m_wbuf * FW * FH + m_y * FW + m_len;
        e_data = int'(id);
      end else begin
        e_clip = 1;
      end
      m_len++;
    end
  endtask

  task automatic step(input logic iv, input logic [PW-1:0] id, input logic [7:0] iy,
                      input logic isw, input logic irst);
    v = iv; d = id; ly = iy; sw = isw; rst = irst;
    model_cycle(iv, id, iy, isw, irst);
    @(posedge clk);
    #1;
    chk("axiov", int'(fb.axiov), e_v);
    if (e_v != 0) begin
      chk("bram_addr", int'(fb.bram_addr), e_addr);
      chk("bram_data_in", int'(fb.bram_data_in), e_data);
    end
    chk("lines_written", int'(lines_written), e_lw);
    chk("display_buf", int'(display_buf), e_disp);
    chk("err_clip", int'(err_clip), e_clip);
    chk("err_line", int'(err_line), e_errl);
    if (fb.axiov) begin
      if (nwr == 0) first_addr = int'(fb.bram_addr);
      last_addr = int'(fb.bram_addr);
      nwr++;
    end
    if (fbs.axiov) nswr++;
  endtask

  task automatic send_line(input int y, input int len, input int swap_at, input int gap);
    nwr = 0; nswr = 0; first_addr = -1; last_addr = -1;
    for (int k = 0; k < len; k++)
      step(1'b1, PW'(k), 8'(y), (k == swap_at), 1'b0);
    for (int g = 0; g < gap; g++)
      step(1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  typedef struct {
    int y; int len; int swap_at;
    int writes; int first; int last; int lw; int disp; int clip;
    int s_errl; int s_writes;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{3,   256, -1, 256, 'h10300, 'h103FF, 1, 0, 0, 0, 256};
    vecs[1] = '{0,   260, -1, 256, 'h10000, 'h100FF, 2, 0, 1, 0, 256};
    vecs[2] = '{5,   10,   4, 10,  'h10500, 'h10509, 0, 1, 1, 0, 10};
    vecs[3] = '{1,   4,   -1, 4,   'h00100, 'h00103, 1, 1, 1, 0, 4};
    vecs[4] = '{2,   3,    0, 3,   'h10200, 'h10202, 1, 0, 1, 0, 3};
    vecs[5] = '{255, 1,   -1, 1,   'h1FF00, 'h1FF00, 2, 0, 1, 1, 0};

    v = 1'b0; d = '0; ly = '0; sw = 1'b0; rst = 1'b1;
    nwr = 0; nswr = 0; first_addr = -1; last_addr = -1;

    // Reset state
    step(1'b0, '0, '0, 1'b0, 1'b1);
    step(1'b0, '0, '0, 1'b0, 1'b1);
    chk("reset bram_addr", int'(fb.bram_addr), 0);
    chk("reset bram_data_in", int'(fb.bram_data_in), 0);
    step(1'b0, '0, '0, 1'b0, 1'b0);

    // Table of line transactions, cumulative from reset
    for (int i = 0; i < 6; i++) begin
      send_line(vecs[i].y, vecs[i].len, vecs[i].swap_at, 2);
      chk($sformatf("vec%0d writes", i), nwr, vecs[i].writes);
      chk($sformatf("vec%0d first_addr", i), first_addr, vecs[i].first);
      chk($sformatf("vec%0d last_addr", i), last_addr, vecs[i].last);
      chk($sformatf("vec%0d lines_written", i), int'(lines_written), vecs[i].lw);
      chk($sformatf("vec%0d display_buf", i), int'(display_buf), vecs[i].disp);
      chk($sformatf("vec%0d err_clip", i), int'(err_clip), vecs[i].clip);
      chk($sformatf("vec%0d short err_line", i), int'(s_err_line), vecs[i].s_errl);
      chk($sformatf("vec%0d short writes", i), nswr, vecs[i].s_writes);
    end
    chk("short lines after reject", int'(s_lines_written), 1);

    // Swap coinciding with the first beat right after reset
    step(1'b0, '0, '0, 1'b0, 1'b1);
    nwr = 0;
    step(1'b1, 12'hABC, 8'd3, 1'b1, 1'b0);
    chk("swap+beat display_buf", int'(display_buf), 1);
    chk("swap+beat addr", int'(fb.bram_addr), 'h00300);
    chk("swap+beat data", int'(fb.bram_data_in), 'hABC);
    step(1'b1, 12'h123, 8'd3, 1'b0, 1'b0);
    chk("swap+beat addr2", int'(fb.bram_addr), 'h00301);
    step(1'b0, '0, '0, 1'b0, 1'b0);
    chk("swap+beat lines", int'(lines_written), 1);

    // Reset asserted at beat 100 of a line
    step(1'b0, '0, '0, 1'b0, 1'b1);
    step(1'b0, '0, '0, 1'b0, 1'b0);
    for (int k = 0; k < 100; k++) step(1'b1, PW'(k + 7), 8'd9, 1'b0, 1'b0);
    chk("pre-reset addr", int'(fb.bram_addr), 'h10900 + 99);
    step(1'b1, 12'h555, 8'd9, 1'b0, 1'b1);
    chk("midreset axiov", int'(fb.axiov), 0);
    chk("midreset addr", int'(fb.bram_addr), 0);
    chk("midreset data", int'(fb.bram_data_in), 0);
    chk("midreset display_buf", int'(display_buf), 0);
    chk("midreset lines", int'(lines_written), 0);
    step(1'b0, '0, '0, 1'b0, 1'b0);
    send_line(9, 3, -1, 1);
    chk("post-reset first", first_addr, 'h10900);
    chk("post-reset lines", int'(lines_written), 1);

    // Saturation of lines_written
    step(1'b0, '0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 260; i++) send_line(i % 256, 1, -1, 1);
    chk("lines_written saturates", int'(lines_written), 255);

    // Randomized traffic against the reference model
    step(1'b0, '0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 300; i++) begin
      int len, y, gap;
      y   = int'($urandom_range(0, 255));
      len = ($urandom_range(0, 9) == 0) ? int'($urandom_range(250, 262))
                                        : int'($urandom_range(1, 20));
      gap = int'($urandom_range(1, 3));
      for (int k = 0; k < len; k++)
        step(1'b1, PW'($urandom), 8'(y), ($urandom_range(0, 39) == 0), 1'b0);
      for (int g = 0; g < gap; g++)
        step(1'b0, PW'($urandom), 8'($urandom), ($urandom_range(0, 5) == 0), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
